// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg: shared widths, FSM states and saturation helpers for the channel accumulator
package psum_accumulator_pkg;
  localparam int PWIDTH = 16;
  localparam int AWIDTH = 24;
  localparam int DWIDTH = 20;
  localparam int DEF_ROW_LEN = 16;
  localparam int CWIDTH = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, LAST} state_t;
  localparam logic signed [AWIDTH+1:0] A_MAX = {3'b000, {(AWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH+1:0] A_MIN = {3'b111, {(AWIDTH-1){1'b0}}};
  localparam logic signed [AWIDTH-1:0] U_MAX = {{(AWIDTH-DWIDTH){1'b0}}, {DWIDTH{1'b1}}};
  localparam logic signed [AWIDTH-1:0] S_MAX = {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] S_MIN = {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  // two guard bits so a three-term sum of AWIDTH values never wraps before clamping
  function automatic logic signed [AWIDTH+1:0] ext_a(input logic signed [AWIDTH-1:0] a);
    return {{2{a[AWIDTH-1]}}, a};
  endfunction
  function automatic logic signed [AWIDTH-1:0] sat_a(input logic signed [AWIDTH+1:0] x);
    return x > A_MAX ? A_MAX[AWIDTH-1:0] : x < A_MIN ? A_MIN[AWIDTH-1:0] : x[AWIDTH-1:0];
  endfunction
  function automatic logic signed [AWIDTH-1:0] sat_add_a(input logic signed [AWIDTH-1:0] a, input logic signed [AWIDTH-1:0] b);
    return sat_a(ext_a(a) + ext_a(b));
  endfunction
  function automatic logic [DWIDTH-1:0] sat_out(input logic signed [AWIDTH-1:0] r, input logic relu);
    if (relu) return r[AWIDTH-1] ? '0 : r > U_MAX ? '1 : r[DWIDTH-1:0];
    return r > S_MAX ? S_MAX[DWIDTH-1:0] : r < S_MIN ? S_MIN[DWIDTH-1:0] : r[DWIDTH-1:0];
  endfunction
endpackage

// File: rtl/psum_accumulator_row_acc_mem.sv
// row_acc_mem: per-pixel accumulator row buffer, combinational read, synchronous write, contents never reset
module row_acc_mem
  import psum_accumulator_pkg::*;
#(
  parameter int DEPTH = DEF_ROW_LEN,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic signed [AWIDTH-1:0] wdata,
  output logic signed [AWIDTH-1:0] rdata
);
  logic signed [AWIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates a row of partial sums over num_ch passes, adds bias, ReLU/saturates to DWIDTH
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int ROW_LEN = DEF_ROW_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CWIDTH-1:0]        num_ch,
  input  logic signed [AWIDTH-1:0] bias_in,
  input  logic                     relu_en,
  input  logic signed [PWIDTH-1:0] psum_in,
  input  logic                     valid_in,
  output logic [DWIDTH-1:0]        data_out,
  output logic                     valid_out,
  output logic                     busy,
  output logic                     done
);
  localparam int XW = $clog2(ROW_LEN);
  state_t state, state_n;
  logic [XW-1:0] pix_cnt, pix_n;
  logic [CWIDTH-1:0] ch_cnt, ch_n, nch_q, nch_eff;
  logic signed [AWIDTH-1:0] bias_q, psum_x, rd, wd, acc, res;
  logic relu_q, we, last_pix, fire;
  assign nch_eff = num_ch == '0 ? CWIDTH'(1) : num_ch;
  assign psum_x = {{(AWIDTH-PWIDTH){psum_in[PWIDTH-1]}}, psum_in};
  assign last_pix = pix_cnt == XW'(ROW_LEN - 1);
  assign we = state == ACCUM && valid_in;
  assign wd = ch_cnt == '0 ? psum_x : sat_add_a(rd, psum_x);
  // single-pass rows never touch the buffer, so stale contents must not leak in
  assign acc = nch_q == CWIDTH'(1) ? '0 : rd;
  assign res = sat_a(ext_a(acc) + ext_a(psum_x) + ext_a(bias_q));
  assign fire = state == LAST && valid_in;
  assign busy = state != IDLE;
  row_acc_mem #(.DEPTH(ROW_LEN)) u_mem (
    .clk  (clk),
    .we   (we),
    .addr (pix_cnt),
    .wdata(wd),
    .rdata(rd)
  );
  always_comb begin
    state_n = state;
    pix_n = pix_cnt;
    ch_n = ch_cnt;
    case (state)
      IDLE: if (start) begin
        state_n = nch_eff == CWIDTH'(1) ? LAST : ACCUM;
        pix_n = '0;
        ch_n = '0;
      end
      ACCUM: if (valid_in) begin
        pix_n = last_pix ? '0 : pix_cnt + 1'b1;
        ch_n = last_pix ? ch_cnt + 1'b1 : ch_cnt;
        state_n = last_pix && ch_n == nch_q - 1'b1 ? LAST : ACCUM;
      end
      LAST: if (valid_in) begin
        pix_n = last_pix ? '0 : pix_cnt + 1'b1;
        state_n = last_pix ? IDLE : LAST;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pix_cnt <= '0;
      ch_cnt <= '0;
      valid_out <= 1'b0;
      done <= 1'b0;
      data_out <= '0;
      nch_q <= CWIDTH'(1);
      bias_q <= '0;
      relu_q <= 1'b0;
    end else begin
      state <= state_n;
      pix_cnt <= pix_n;
      ch_cnt <= ch_n;
      valid_out <= fire;
      done <= fire && last_pix;
      if (fire) data_out <= sat_out(res, relu_q);
      if (state == IDLE && start) begin
        nch_q <= nch_eff;
        bias_q <= bias_in;
        relu_q <= relu_en;
      end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: randomized self-checking bench against an arithmetic row model, ROW_LEN=4
module tb_psum_accumulator;
  logic clk = 1'b0;
  logic reset, start, relu_en, valid_in;
  logic [7:0] num_ch;
  logic [23:0] bias_in;
  logic [15:0] psum_in;
  logic [19:0] data_out;
  logic valid_out, busy, done;
  int errors = 0;
  int checks = 0;
  int ps [8][4];

  psum_accumulator #(.ROW_LEN(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_ch(num_ch), .bias_in(bias_in),
    .relu_en(relu_en), .psum_in(psum_in), .valid_in(valid_in), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat_a(input longint x);
    return x > 8388607 ? 8388607 : x < -8388608 ? -8388608 : x;
  endfunction

  function automatic logic [19:0] sat_o(input longint r, input bit relu);
    if (relu) return r < 0 ? 20'h0 : r > 1048575 ? 20'hFFFFF : r[19:0];
    return r > 524287 ? 20'h7FFFF : r < -524288 ? 20'h80000 : r[19:0];
  endfunction

  task automatic set_row(input int c, input int a, input int b, input int d, input int e);
    ps[c][0] = a; ps[c][1] = b; ps[c][2] = d; ps[c][3] = e;
  endtask

  // gap < 0 picks a random 0..2 idle cycles after every beat
  task automatic run_row(input int nch, input longint bias, input bit relu, input int gap);
    int eff, g;
    longint acc, r;
    bit last, fin;
    logic [19:0] want [4];
    eff = nch == 0 ? 1 : nch;
    for (int p = 0; p < 4; p++) begin
      acc = ps[0][p];
      for (int c = 1; c < eff - 1; c++) acc = sat_a(acc + ps[c][p]);
      r = eff == 1 ? sat_a(ps[0][p] + bias) : sat_a(acc + ps[eff-1][p] + bias);
      want[p] = sat_o(r, relu);
    end
    start = 1'b1; num_ch = 8'(nch); bias_in = bias[23:0]; relu_en = relu;
    valid_in = 1'($urandom_range(0, 1)); psum_in = 16'($urandom);
    tick();
    start = 1'b0;
    check("busy_start", busy, 1);
    for (int c = 0; c < eff; c++)
      for (int p = 0; p < 4; p++) begin
        last = c == eff - 1;
        fin = last && p == 3;
        valid_in = 1'b1; psum_in = 16'(ps[c][p]);
        start = !fin && $urandom_range(0, 3) == 0;
        num_ch = 8'($urandom); bias_in = 24'($urandom); relu_en = 1'($urandom);
        tick();
        start = 1'b0;
        check("valid", valid_out, last);
        if (last) check("data", data_out, want[p]);
        check("done", done, fin);
        check("busy", busy, !fin);
        g = gap < 0 ? $urandom_range(0, 2) : gap;
        repeat (g) begin
          valid_in = 1'b0; psum_in = 16'($urandom);
          tick();
          check("gap_valid", valid_out, 0);
          if (last) check("hold", data_out, want[p]);
        end
      end
    valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; valid_in = 1'b0; relu_en = 1'b0;
    num_ch = '0; bias_in = '0; psum_in = '0;
    repeat (5) begin
      start = 1'($urandom); valid_in = 1'($urandom); psum_in = 16'($urandom);
      num_ch = 8'($urandom); bias_in = 24'($urandom); relu_en = 1'($urandom);
      tick();
      check("rst_data", data_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      valid_in = 1'($urandom); psum_in = 16'($urandom);
      tick();
      check("idle_valid", valid_out, 0);
      check("idle_busy", busy, 0);
    end
    valid_in = 1'b0;
    set_row(0, 1, 2, 3, 4);
    run_row(1, 10, 1, 0);
    set_row(0, 1, 2, 3, 4); set_row(1, 10, 20, 30, 40); set_row(2, 100, 200, 300, 400);
    run_row(3, 0, 1, 0);
    run_row(3, 0, 0, 2);
    set_row(0, 5, 0, 0, 0);
    run_row(1, -100, 1, 0);
    run_row(1, -100, 0, 0);
    run_row(1, 1 << 20, 1, 0);
    run_row(1, 1 << 20, 0, 0);
    set_row(0, 1, 2, 3, 4);
    run_row(0, 10, 1, -1);
    set_row(0, 32767, 32767, 32767, 32767); set_row(1, 32767, 32767, 32767, 32767);
    run_row(2, 8388607, 1, 0);
    set_row(0, -32768, -32768, -32768, -32768); set_row(1, -32768, -32768, -32768, -32768);
    run_row(2, -8388608, 0, 0);
    // abort in the middle of pass 1 of a three-pass row
    start = 1'b1; num_ch = 8'd3; bias_in = '0; relu_en = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1; psum_in = 16'(1000 + i);
      tick();
    end
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", valid_out, 0);
    check("arst_data", data_out, 0);
    check("arst_done", done, 0);
    #2 reset = 1'b1;
    repeat (2) begin
      valid_in = 1'b1; psum_in = 16'($urandom);
      tick();
      check("post_rst_valid", valid_out, 0);
      check("post_rst_busy", busy, 0);
    end
    valid_in = 1'b0;
    set_row(0, 7, 8, 9, 10);
    run_row(1, 0, 0, 0);
    // abort while an output beat is on the bus
    start = 1'b1; num_ch = 8'd1; bias_in = '0; relu_en = 1'b0;
    tick();
    start = 1'b0; valid_in = 1'b1; psum_in = 16'd50;
    tick();
    valid_in = 1'b0;
    check("last_valid", valid_out, 1);
    check("last_data", data_out, 50);
    #2 reset = 1'b0;
    #1;
    check("arst2_valid", valid_out, 0);
    check("arst2_data", data_out, 0);
    check("arst2_busy", busy, 0);
    #2 reset = 1'b1;
    tick();
    repeat (12) begin
      int nch;
      longint bias;
      nch = $urandom_range(0, 5);
      for (int c = 0; c < 6; c++)
        for (int p = 0; p < 4; p++) ps[c][p] = int'($urandom_range(0, 65535)) - 32768;
      bias = $urandom_range(0, 2) == 0 ? longint'(int'($urandom_range(0, 16777215)) - 8388608)
                                       : longint'(int'($urandom_range(0, 4000)) - 2000);
      run_row(nch, bias, 1'($urandom), -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Channel-accumulation stage directly upstream of the max-pool stage.
- Receives signed partial sums from the MAC array, one output pixel per beat, one row of ROW_LEN pixels per input-channel pass.
- Accumulates each pixel across num_ch passes in a row buffer, then adds bias, applies optional ReLU, saturates to DWIDTH and streams data_out/valid_out into max_pool.data_in/valid_in.

Parameters:
PWIDTH, 16, signed partial-sum input width
AWIDTH, 24, signed accumulator and bias width
DWIDTH, 20, output width (matches max_pool DWIDTH)
ROW_LEN, 16, pixels per row pass (row-buffer depth)
CWIDTH, 8, width of channel-count configuration

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  one-cycle pulse; latches num_ch, bias_in, relu_en
num_ch  in  CWIDTH  input channels to accumulate; 0 treated as 1
bias_in  in  AWIDTH  signed bias added on last pass
relu_en  in  1  1: clamp negatives to 0
psum_in  in  PWIDTH  signed partial sum
valid_in  in  1  psum_in beat valid
data_out  out  DWIDTH  finished pixel
valid_out  out  1  data_out valid, one cycle per pixel
busy  out  1  high from start until done
done  out  1  one-cycle pulse with last valid_out of row

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; pix_cnt, ch_cnt, data_out, valid_out, busy and done all 0. Row buffer not cleared (pass 0 overwrites it).
- FSM states IDLE, ACCUM, LAST.
- IDLE: valid_in ignored. On start, latch config, pix_cnt=0, ch_cnt=0, busy=1. Go to LAST if effective num_ch==1, else ACCUM.
- ACCUM: each valid_in beat handles pixel pix_cnt.
  - ch_cnt==0: buf[pix]=sext(psum_in).
  - Otherwise: buf[pix]=sat_A(buf[pix]+psum_in).
  - pix_cnt wraps at ROW_LEN-1, then ch_cnt increments. Go to LAST when ch_cnt reaches num_ch-1.
- LAST: on each valid_in beat, r = sat_A(acc+psum_in+bias), where acc=0 if num_ch==1, else buf[pix].
  - Register data_out=sat_D(r); valid_out=1 for exactly the next cycle (latency 1).
  - On pix==ROW_LEN-1: done=1 in the same cycle as that valid_out, busy=0 in that cycle, return to IDLE.
- sat_D:
  - relu_en=1: r<0 gives 0; r>2^DWIDTH-1 gives 2^DWIDTH-1; otherwise r.
  - relu_en=0: clamp r to the signed DWIDTH range [-2^(DWIDTH-1), 2^(DWIDTH-1)-1], two's complement.
- sat_A: saturating signed add at AWIDTH bits; no wrap-around.
- valid_in low: counters and buffer hold, valid_out=0. Gaps between beats are legal in any state.
- start while busy: ignored, config unchanged.
- Reset mid-operation: immediate abort, no further valid_out. The next start runs cleanly.
- data_out holds its last value while valid_out=0.

Decomposition:
- Shared package holds:
  - width localparams;
  - state enum {IDLE, ACCUM, LAST};
  - functions sat_add_a and sat_out (relu/clamp).
- One sub-module, row_acc_mem: ROW_LEN x AWIDTH register array, combinational read, synchronous write on we. No reset on contents.

Test Plan (bench overrides ROW_LEN=4):
1. Hold reset=0 with random inputs -> data_out=0, valid_out=0, busy=0, done=0. Release; no valid_out until start.
2. start num_ch=1, bias=10, relu_en=1; psums 1,2,3,4 -> data_out 11,12,13,14, each one cycle after its beat. done with the 14, busy drops.
3. num_ch=3, bias=0; passes [1,2,3,4], [10,20,30,40], [100,200,300,400] -> valid_out only during pass 3, values 111,222,333,444. Repeat with 2-cycle gaps between beats -> identical outputs.
4. num_ch=1, bias=-100, psum 5, 0, 0, 0:
   - relu_en=1 -> 0,0,0,0.
   - relu_en=0 -> 0xFFFA1,...
   - bias=2^20: relu_en=1 -> 0xFFFFF; relu_en=0 -> 0x7FFFF.
5. num_ch=2; pass 0 all psums 32767 with bias=2^23-1 -> no overflow wrap, output saturated (0xFFFFF with relu_en=1). num_ch=0 behaves exactly as num_ch=1.
6. Assert reset mid pass 1 of num_ch=3 -> outputs 0 asynchronously, busy 0. New start with num_ch=1, bias=0, psums 7,8,9,10 -> 7,8,9,10 (stale buffer unused). A start issued while busy is ignored.
